// File: rtl/network_rx.sv
// Receive side of the tile endpoint: decodes incoming remote requests to DMEM,
// icache or tile CSRs, owns the CSRs, and returns one response per accepted packet.
module network_rx #(
    parameter int data_width_p          = 32,
    parameter int addr_width_p          = 28,
    parameter int epa_byte_addr_width_p = 18,
    parameter int dmem_size_p           = 1024,
    parameter int icache_entries_p      = 1024,
    parameter int icache_tag_width_p    = 12,
    parameter int x_subcord_width_p     = 3,
    parameter int y_subcord_width_p     = 3
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic                                                  pkt_v_i,
    input  logic                                                  pkt_we_i,
    input  logic                                                  pkt_amo_i,
    input  logic [addr_width_p-1:0]                               pkt_addr_i,
    input  logic [data_width_p-1:0]                               pkt_data_i,
    input  logic [3:0]                                            pkt_mask_i,
    output logic                                                  pkt_yumi_o,
    output logic                                                  returning_v_o,
    output logic [data_width_p-1:0]                               returning_data_o,
    output logic                                                  dmem_v_o,
    output logic                                                  dmem_w_o,
    output logic [$clog2(dmem_size_p)-1:0]                        dmem_addr_o,
    output logic [data_width_p-1:0]                               dmem_data_o,
    output logic [3:0]                                            dmem_mask_o,
    input  logic                                                  dmem_yumi_i,
    input  logic [data_width_p-1:0]                               dmem_data_i,
    output logic                                                  icache_v_o,
    output logic [$clog2(icache_entries_p)+icache_tag_width_p-1:0] icache_pc_o,
    output logic [data_width_p-1:0]                               icache_instr_o,
    input  logic                                                  icache_yumi_i,
    output logic                                                  freeze_o,
    output logic [x_subcord_width_p-1:0]                          tgo_x_o,
    output logic [y_subcord_width_p-1:0]                          tgo_y_o,
    output logic                                                  dram_enable_o,
    output logic [$clog2(icache_entries_p)+icache_tag_width_p-1:0] pc_init_o,
    output logic                                                  error_o
);
    localparam int W       = epa_byte_addr_width_p - 2;
    localparam int DMEM_AW = $clog2(dmem_size_p);
    localparam int PC_W    = $clog2(icache_entries_p) + icache_tag_width_p;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]                   r_state;
    logic                         r_resp_dmem;
    logic [data_width_p-1:0]      r_resp_data;
    logic                         r_freeze;
    logic [x_subcord_width_p-1:0] r_tgo_x;
    logic [y_subcord_width_p-1:0] r_tgo_y;
    logic                         r_dram_enable;
    logic [PC_W-1:0]              r_pc_init;

    logic                    w_v, w_is_icache, w_is_csr, w_is_dmem, w_illegal;
    logic [2:0]              w_csr_sel;
    logic                    w_csr_we, w_csr_ld, w_dmem_ld;
    logic [data_width_p-1:0] w_csr_rdata;
    logic                    w_unused;

    assign w_unused = ^pkt_addr_i[addr_width_p-1:PC_W];

    // Address decode: icache bit has priority over the CSR bit.
    assign w_v         = pkt_v_i & ~reset_i;
    assign w_is_icache = pkt_addr_i[W];
    assign w_is_csr    = ~w_is_icache & pkt_addr_i[W-1];
    assign w_is_dmem   = ~w_is_icache & ~w_is_csr;
    assign w_csr_sel   = pkt_addr_i[2:0];
    assign w_illegal   = pkt_amo_i
                       | (w_is_icache & ~pkt_we_i)
                       | (w_is_csr & (w_csr_sel > 3'd4));

    assign dmem_v_o       = w_v & w_is_dmem & ~w_illegal;
    assign dmem_w_o       = pkt_we_i;
    assign dmem_addr_o    = pkt_addr_i[DMEM_AW-1:0];
    assign dmem_data_o    = pkt_data_i;
    assign dmem_mask_o    = pkt_mask_i;
    assign icache_v_o     = w_v & w_is_icache & ~w_illegal;
    assign icache_pc_o    = pkt_addr_i[PC_W-1:0];
    assign icache_instr_o = pkt_data_i;

    always_comb begin
        pkt_yumi_o = 1'b0;
        if (w_illegal || w_is_csr) pkt_yumi_o = w_v;
        else if (w_is_dmem)        pkt_yumi_o = dmem_v_o & dmem_yumi_i;
        else                       pkt_yumi_o = icache_v_o & icache_yumi_i;
    end

    assign error_o   = pkt_yumi_o & w_illegal;
    assign w_csr_we  = pkt_yumi_o & w_is_csr & pkt_we_i & ~w_illegal;
    assign w_csr_ld  = pkt_yumi_o & w_is_csr & ~pkt_we_i & ~w_illegal;
    assign w_dmem_ld = pkt_yumi_o & w_is_dmem & ~pkt_we_i & ~w_illegal;

    always_comb begin
        w_csr_rdata = '0;
        case (w_csr_sel)
            3'd0:    w_csr_rdata = data_width_p'(r_freeze);
            3'd1:    w_csr_rdata = data_width_p'(r_tgo_x);
            3'd2:    w_csr_rdata = data_width_p'(r_tgo_y);
            3'd3:    w_csr_rdata = data_width_p'(r_pc_init);
            3'd4:    w_csr_rdata = data_width_p'(r_dram_enable);
            default: w_csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_freeze      <= 1'b1;
            r_tgo_x       <= '0;
            r_tgo_y       <= '0;
            r_dram_enable <= 1'b1;
            r_pc_init     <= '0;
        end else if (w_csr_we) begin
            // Full-word write; the byte mask does not apply to CSRs.
            case (w_csr_sel)
                3'd0:    r_freeze      <= pkt_data_i[0];
                3'd1:    r_tgo_x       <= pkt_data_i[x_subcord_width_p-1:0];
                3'd2:    r_tgo_y       <= pkt_data_i[y_subcord_width_p-1:0];
                3'd3:    r_pc_init     <= pkt_data_i[PC_W-1:0];
                3'd4:    r_dram_enable <= pkt_data_i[0];
                default: ;
            endcase
        end
    end

    // DMEM load data arrives from the core in the response cycle, so only the
    // selection is registered; CSR load data is captured at accept time.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_resp_dmem <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_state     <= pkt_yumi_o ? ST_RESP : ST_IDLE;
            r_resp_dmem <= w_dmem_ld;
            r_resp_data <= w_csr_ld ? w_csr_rdata : '0;
        end
    end

    assign returning_v_o    = (r_state == ST_RESP);
    assign returning_data_o = r_resp_dmem ? dmem_data_i : r_resp_data;

    assign freeze_o      = r_freeze;
    assign tgo_x_o       = r_tgo_x;
    assign tgo_y_o       = r_tgo_y;
    assign dram_enable_o = r_dram_enable;
    assign pc_init_o     = r_pc_init;
endmodule

// File: tb/tb_network_rx.sv
// Directed bench for network_rx: a vector table of single packets plus
// hand-written sequences for grant stalls, back-to-back loads and reset.
module tb_network_rx;
    logic        clk = 0;
    logic        reset;
    logic        pkt_v, pkt_we, pkt_amo;
    logic [27:0] pkt_addr;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_mask;
    logic        pkt_yumi, ret_v;
    logic [31:0] ret_data;
    logic        dmem_v, dmem_w;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_yumi;
    logic [31:0] dmem_rdata;
    logic        icache_v;
    logic [21:0] icache_pc;
    logic [31:0] icache_instr;
    logic        icache_yumi;
    logic        freeze;
    logic [2:0]  tgo_x, tgo_y;
    logic        dram_en;
    logic [21:0] pc_init;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    network_rx dut (
        .clk_i(clk), .reset_i(reset),
        .pkt_v_i(pkt_v), .pkt_we_i(pkt_we), .pkt_amo_i(pkt_amo),
        .pkt_addr_i(pkt_addr), .pkt_data_i(pkt_data), .pkt_mask_i(pkt_mask),
        .pkt_yumi_o(pkt_yumi), .returning_v_o(ret_v), .returning_data_o(ret_data),
        .dmem_v_o(dmem_v), .dmem_w_o(dmem_w), .dmem_addr_o(dmem_addr),
        .dmem_data_o(dmem_wdata), .dmem_mask_o(dmem_mask),
        .dmem_yumi_i(dmem_yumi), .dmem_data_i(dmem_rdata),
        .icache_v_o(icache_v), .icache_pc_o(icache_pc), .icache_instr_o(icache_instr),
        .icache_yumi_i(icache_yumi),
        .freeze_o(freeze), .tgo_x_o(tgo_x), .tgo_y_o(tgo_y),
        .dram_enable_o(dram_en), .pc_init_o(pc_init), .error_o(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        we, amo;
        logic [27:0] addr;
        logic [31:0] data;
        logic        dyumi, iyumi;
        logic [31:0] rdata;
        logic        e_yumi, e_err, e_dmem_v, e_icache_v;
        logic [31:0] e_data;
    } vec_t;

    localparam logic [27:0] CSR = 28'h0008000;
    localparam logic [27:0] ICA = 28'h0010000;

    vec_t vecs[14];

    initial begin
        //         we  amo addr       data          dy iy rdata         yumi err dv iv resp
        vecs[0]  = '{0, 0, CSR+0,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h1};
        vecs[1]  = '{1, 0, CSR+0,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0};
        vecs[2]  = '{1, 0, CSR+1,     32'h5,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0};
        vecs[3]  = '{0, 0, CSR+1,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h5};
        vecs[4]  = '{0, 0, CSR+5,     32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 32'h0};
        vecs[5]  = '{1, 1, 28'h10,    32'h1234,     1, 0, 32'h0,        1, 1, 0, 0, 32'h0};
        vecs[6]  = '{1, 0, 28'h10,    32'hDEADBEEF, 1, 0, 32'h0,        1, 0, 1, 0, 32'h0};
        vecs[7]  = '{0, 0, 28'h10,    32'h0,        1, 0, 32'hDEADBEEF, 1, 0, 1, 0, 32'hDEADBEEF};
        vecs[8]  = '{1, 0, ICA+28'h40,32'h00000013, 0, 1, 32'h0,        1, 0, 0, 1, 32'h0};
        vecs[9]  = '{0, 0, ICA+28'h40,32'h0,        0, 1, 32'h0,        1, 1, 0, 0, 32'h0};
        vecs[10] = '{1, 0, CSR+3,     32'hFFFFFFFF, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0};
        vecs[11] = '{0, 0, CSR+3,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h003FFFFF};
        vecs[12] = '{1, 0, CSR+4,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0};
        vecs[13] = '{0, 0, CSR+4,     32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0};

        reset = 1; pkt_v = 0; pkt_we = 0; pkt_amo = 0; pkt_addr = '0;
        pkt_data = '0; pkt_mask = 4'hF; dmem_yumi = 0; dmem_rdata = '0; icache_yumi = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_freeze", 32'(freeze), 32'h1);
        chk("rst_dram_en", 32'(dram_en), 32'h1);
        chk("rst_tgo", {26'h0, tgo_x, tgo_y}, 32'h0);
        chk("rst_pc_init", 32'(pc_init), 32'h0);
        chk("rst_ret_v", 32'(ret_v), 32'h0);
        chk("rst_yumi", 32'(pkt_yumi), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        foreach (vecs[i]) begin
            pkt_v = 1; pkt_we = vecs[i].we; pkt_amo = vecs[i].amo;
            pkt_addr = vecs[i].addr; pkt_data = vecs[i].data;
            dmem_yumi = vecs[i].dyumi; icache_yumi = vecs[i].iyumi;
            #3;
            chk($sformatf("v%0d_yumi", i), 32'(pkt_yumi), 32'(vecs[i].e_yumi));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_dmem_v", i), 32'(dmem_v), 32'(vecs[i].e_dmem_v));
            chk($sformatf("v%0d_icache_v", i), 32'(icache_v), 32'(vecs[i].e_icache_v));
            if (vecs[i].e_dmem_v) begin
                chk($sformatf("v%0d_dmem_w", i), 32'(dmem_w), 32'(vecs[i].we));
                chk($sformatf("v%0d_dmem_addr", i), 32'(dmem_addr), 32'(vecs[i].addr[9:0]));
            end
            if (vecs[i].e_icache_v) begin
                // pc is the low 22 address bits, which include the icache select bit
                chk("icache_pc", 32'(icache_pc), 32'h00010040);
                chk("icache_instr", icache_instr, 32'h00000013);
            end
            @(posedge clk); #1;
            pkt_v = 0; dmem_yumi = 0; icache_yumi = 0;
            dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_ret_v", i), 32'(ret_v), 32'(vecs[i].e_yumi));
            chk($sformatf("v%0d_ret_data", i), ret_data, vecs[i].e_data);
            if (i == 1) chk("freeze_after_store", 32'(freeze), 32'h0);
            if (i == 10) chk("pc_init_after_store", 32'(pc_init), 32'h003FFFFF);
        end
        @(posedge clk); #1;
        chk("idle_ret_v", 32'(ret_v), 32'h0);

        // DMEM load stalled by the core for three cycles.
        pkt_v = 1; pkt_we = 0; pkt_amo = 0; pkt_addr = 28'h10; dmem_yumi = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("stall_yumi", 32'(pkt_yumi), 32'h0);
            chk("stall_dmem_v", 32'(dmem_v), 32'h1);
            @(posedge clk); #1;
            chk("stall_ret_v", 32'(ret_v), 32'h0);
        end
        dmem_yumi = 1;
        #3 chk("grant_yumi", 32'(pkt_yumi), 32'h1);
        @(posedge clk); #1;
        pkt_v = 0; dmem_yumi = 0; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("grant_ret_v", 32'(ret_v), 32'h1);
        chk("grant_ret_data", ret_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("grant_single_resp", 32'(ret_v), 32'h0);

        // Four back-to-back DMEM loads with grant every cycle.
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                pkt_v = 1; pkt_we = 0; pkt_addr = 28'(k); dmem_yumi = 1;
            end else begin
                pkt_v = 0; dmem_yumi = 0;
            end
            if (k > 0) dmem_rdata = 32'h1000 + 32'(k - 1);
            #1;
            if (k > 0) begin
                chk($sformatf("b2b%0d_ret_v", k - 1), 32'(ret_v), 32'h1);
                chk($sformatf("b2b%0d_ret_data", k - 1), ret_data, 32'h1000 + 32'(k - 1));
            end
            if (k < 4) chk($sformatf("b2b%0d_yumi", k), 32'(pkt_yumi), 32'h1);
            @(posedge clk); #1;
        end
        chk("b2b_end_ret_v", 32'(ret_v), 32'h0);

        // Reset asserted while a response is pending.
        pkt_v = 1; pkt_we = 1; pkt_addr = CSR + 2; pkt_data = 32'h3;
        @(posedge clk); #1;
        pkt_v = 0;
        chk("pre_rst_tgo_y", 32'(tgo_y), 32'h3);
        chk("pre_rst_ret_v", 32'(ret_v), 32'h1);
        reset = 1;
        @(posedge clk); #1;
        chk("midrst_ret_v", 32'(ret_v), 32'h0);
        chk("midrst_freeze", 32'(freeze), 32'h1);
        chk("midrst_tgo", {26'h0, tgo_x, tgo_y}, 32'h0);
        chk("midrst_dram_en", 32'(dram_en), 32'h1);
        chk("midrst_pc_init", 32'(pc_init), 32'h0);
        reset = 0;
        @(posedge clk); #1;
        chk("post_rst_ret_v", 32'(ret_v), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
